cordic_arbiter: RTL
===================

# cordic_arbiter

Shares one pipelined `parallel` CORDIC rotator between two independent requesters. Each requester presents an angle and a start vector with a valid/ready handshake. The block issues at most one operation per clock to the rotator and tracks each operation's owner through the fixed rotator latency. It then routes the cosine/sine result back to the owning requester as a registered, valid-tagged response. It sits between the waveform/NCO clients and the single `parallel` instance.

## Interface
- `SZ`, 16 — data width of x/y/cosine/sine.
- `AW`, 32 — angle width; full scale 2^32 = 360°.
- `PIPE_LAT`, 16 — clocks from a change on the rotator inputs to the matching `cosine`/`sine` output; minimum 1.

- `clock`  in  1  — single clock; all logic on its rising edge.
- `reset_n`  in  1  — synchronous, active-low reset.
- `req0_valid` / `req1_valid`  in  1 each  — request present.
- `req0_ready` / `req1_ready`  out  1 each  — grant; combinational from valids and arbitration state.
- `req0_angle` / `req1_angle`  in  AW each  — rotation angle.
- `req0_x`, `req0_y` / `req1_x`, `req1_y`  in  SZ each  — start vector, already pre-scaled by 1/1.647.
- `cor_angle`  out  AW  — registered drive to the rotator `angle`.
- `cor_x_start`, `cor_y_start`  out  SZ each  — registered drive to the rotator `x_start` / `y_start`.
- `cor_cosine`, `cor_sine`  in  SZ each  — rotator outputs.
- `rsp0_valid` / `rsp1_valid`  out  1 each  — one-cycle response strobe; no backpressure.
- `rsp0_cos`, `rsp0_sin` / `rsp1_cos`, `rsp1_sin`  out  SZ each  — registered result.
- `busy`  out  1  — high while any operation is in flight.

## Operation
- A request is accepted on a rising edge where `reqN_valid && reqN_ready`.
- At most one ready is high per cycle. `reqN_ready` is never high when `reqN_valid` is low.
- Arbitration, default build: 2-way round-robin with pointer `rr`.
  - If both valid, grant the requester indicated by `rr`.
  - If exactly one valid, grant it.
  - After each accept, `rr` flips to the other requester. `rr` is unchanged on idle cycles.
- On accept:
  - `cor_angle`, `cor_x_start`, `cor_y_start` load the granted request's fields.
  - A tag entry {valid=1, owner=N} enters the head of a `PIPE_LAT+1`-deep tag shift register.
- Idle cycle: the `cor_*` outputs hold their previous values, and a bubble {valid=0} enters the tag shift register.
- Tag shift register advances every clock. No stall exists anywhere: the rotator cannot stall.
- When the tail entry is valid, the response register of owner N captures `cor_cosine`/`cor_sine` and pulses `rspN_valid` for one cycle. The other requester's response registers hold their values, with valid=0.
- `busy` = OR of all tag valid bits.
- Width rules:
  - Angles pass through unmodified; wrap at 2^32 is native (359° + 1° = 0°).
  - No arithmetic on x/y; values pass straight through.
- Reset, when `reset_n` is low at an edge:
  - All outputs go to 0.
  - `rr` = 0 (requester 0 preferred first).
  - The tag register is cleared.
- Reset mid-operation: in-flight results are discarded. No `rsp*_valid` pulses until a new request completes, even though the rotator keeps producing data.

## Timing
- Ready: combinational, same cycle as valid.
- Accept at edge k → `cor_*` change after edge k → rotator output valid after edge k+PIPE_LAT → `rspN_valid` high after edge k+PIPE_LAT+1.
- Total latency: PIPE_LAT+1 clocks from accept to response.
- Throughput: 1 accept per clock aggregate. With both requesters saturating in the default build, each gets every other cycle.
- Responses leave in issue order. Per-requester order is preserved.
- Simultaneous response and accept in the same cycle are independent.

## Configuration
- `CORDIC_ARB_FIXED_PRIO_EN` defined:
  - Requester 0 has strict priority; requester 1 is granted only when `req0_valid` is low.
  - `rr` is not implemented.
- Not defined: the round-robin behaviour described above.

## Test plan
- **Single request.** PIPE_LAT=16. req0: angle=0x20000000 (45°), x=19429, y=0, held valid one cycle.
  - `req0_ready`=1 that cycle.
  - `rsp0_valid` exactly 17 clocks later, with cos≈sin≈22627 (±16).
  - `rsp1_valid` never asserts.
- **Contention.** Both requesters valid continuously for 8 cycles after reset.
  - Grants alternate 0,1,0,1…
  - Each requester receives 4 responses, in order, 17 clocks after their respective accepts.
  - With `CORDIC_ARB_FIXED_PRIO_EN`: req0 gets all 8 grants and req1 gets none until req0 drops.
- **Angle sweep.** req1 sweeps 0..359° (angle = i·2^32/360), one per clock.
  - 360 consecutive `rsp1_valid` pulses.
  - Results match cos/sin·32000 within ±16, including wrap at 359°→0°.
- **Bubbles.** req0 valid on alternate cycles.
  - `rsp0_valid` shows the same alternating pattern, shifted by 17 clocks.
  - `busy` stays high throughout and falls 17 clocks after the last accept.
- **Reset mid-flight.** Issue 5 requests, then assert `reset_n`=0 for one clock after 8 cycles.
  - All outputs are 0 the following cycle.
  - No `rsp*_valid` pulses for the discarded operations.
  - A fresh request afterward returns its response after 17 clocks.

Source files
------------

// File: rtl/cordic_arbiter.sv
// -----------------------------------------------------------------------------
// cordic_arbiter
//
// Shares one pipelined CORDIC rotator between two requesters. Each cycle at
// most one request is granted and registered onto the rotator inputs. A tag
// shift register (PIPE_LAT+1 deep) tracks the owner of each issued operation,
// so that the rotator result can be steered back to that requester as a
// registered, one-cycle response strobe.
//
// Build option:
//   CORDIC_ARB_FIXED_PRIO_EN  defined     -> requester 0 has strict priority
//                             not defined -> 2-way round-robin (pointer rr)
//
// Ports:
//   clock, reset_n                 clock, synchronous active-low reset
//   reqN_valid / reqN_ready        request handshake (ready is combinational)
//   reqN_angle, reqN_x, reqN_y     request fields (angle full scale = 360 deg)
//   cor_angle, cor_x_start,
//   cor_y_start                    registered drive to the rotator
//   cor_cosine, cor_sine           rotator results, PIPE_LAT clocks later
//   rspN_valid, rspN_cos, rspN_sin registered response per requester
//   busy                           high while any operation is in flight
// -----------------------------------------------------------------------------
module cordic_arbiter #(
    parameter int SZ       = 16,
    parameter int AW       = 32,
    parameter int PIPE_LAT = 16
) (
    input  logic          clock,
    input  logic          reset_n,

    input  logic          req0_valid,
    output logic          req0_ready,
    input  logic [AW-1:0] req0_angle,
    input  logic [SZ-1:0] req0_x,
    input  logic [SZ-1:0] req0_y,

    input  logic          req1_valid,
    output logic          req1_ready,
    input  logic [AW-1:0] req1_angle,
    input  logic [SZ-1:0] req1_x,
    input  logic [SZ-1:0] req1_y,

    output logic [AW-1:0] cor_angle,
    output logic [SZ-1:0] cor_x_start,
    output logic [SZ-1:0] cor_y_start,
    input  logic [SZ-1:0] cor_cosine,
    input  logic [SZ-1:0] cor_sine,

    output logic          rsp0_valid,
    output logic [SZ-1:0] rsp0_cos,
    output logic [SZ-1:0] rsp0_sin,

    output logic          rsp1_valid,
    output logic [SZ-1:0] rsp1_cos,
    output logic [SZ-1:0] rsp1_sin,

    output logic          busy
);

    logic grant0;
    logic grant1;
    logic accept;

    // Tag shift register: bit 0 is the head (just issued), bit PIPE_LAT the tail
    // whose rotator result is present on cor_cosine/cor_sine this cycle.
    logic [PIPE_LAT:0] tag_vld_p;
    logic [PIPE_LAT:0] tag_own_p;
    logic              tail_vld;
    logic              tail_own;

`ifdef CORDIC_ARB_FIXED_PRIO_EN
    always_comb begin
        grant0 = req0_valid;
        grant1 = req1_valid & ~req0_valid;
    end
`else
    logic rr;

    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (req0_valid && req1_valid) begin
            grant0 = ~rr;
            grant1 = rr;
        end else begin
            grant0 = req0_valid;
            grant1 = req1_valid;
        end
    end

    // Pointer toggles on every accept and holds on idle cycles.
    always_ff @(posedge clock) begin
        if (!reset_n)
            rr <= 1'b0;
        else if (accept)
            rr <= ~rr;
    end
`endif

    assign req0_ready = grant0;
    assign req1_ready = grant1;
    assign accept     = grant0 | grant1;

    // ---- issue stage: registered rotator drive, held on idle cycles ----
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            cor_angle   <= '0;
            cor_x_start <= '0;
            cor_y_start <= '0;
        end else if (grant0) begin
            cor_angle   <= req0_angle;
            cor_x_start <= req0_x;
            cor_y_start <= req0_y;
        end else if (grant1) begin
            cor_angle   <= req1_angle;
            cor_x_start <= req1_x;
            cor_y_start <= req1_y;
        end
    end

    // ---- tag pipeline: owner tracking through the rotator latency ----
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            tag_vld_p <= '0;
            tag_own_p <= '0;
        end else begin
            tag_vld_p <= {tag_vld_p[PIPE_LAT-1:0], accept};
            tag_own_p <= {tag_own_p[PIPE_LAT-1:0], grant1};
        end
    end

    assign tail_vld = tag_vld_p[PIPE_LAT];
    assign tail_own = tag_own_p[PIPE_LAT];
    assign busy     = |tag_vld_p;

    // ---- response stage: capture rotator output for the tail's owner ----
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            rsp0_valid <= 1'b0;
            rsp0_cos   <= '0;
            rsp0_sin   <= '0;
            rsp1_valid <= 1'b0;
            rsp1_cos   <= '0;
            rsp1_sin   <= '0;
        end else begin
            rsp0_valid <= tail_vld & ~tail_own;
            rsp1_valid <= tail_vld & tail_own;
            if (tail_vld && !tail_own) begin
                rsp0_cos <= cor_cosine;
                rsp0_sin <= cor_sine;
            end
            if (tail_vld && tail_own) begin
                rsp1_cos <= cor_cosine;
                rsp1_sin <= cor_sine;
            end
        end
    end

endmodule
